// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for common-anode multi-digit 7-segment displays.
// Double-buffered digit data, programmable dwell and anti-ghosting guard interval.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 1200,
    parameter int GUARD      = 16,
    parameter int LZ_BLANK   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic                      load,
    output logic [6:0]                seg,
    output logic                      seg_dp,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] font_n(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h3F;
            4'h1: f = 7'h06;
            4'h2: f = 7'h5B;
            4'h3: f = 7'h4F;
            4'h4: f = 7'h66;
            4'h5: f = 7'h6D;
            4'h6: f = 7'h7D;
            4'h7: f = 7'h07;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h67;
            4'hA: f = 7'h77;
            4'hB: f = 7'h7C;
            4'hC: f = 7'h39;
            4'hD: f = 7'h5E;
            4'hE: f = 7'h79;
            default: f = 7'h71;
        endcase
        return ~f;
    endfunction

    logic [CW-1:0]             cnt, cnt_nxt;
    logic [IW-1:0]             idx, idx_nxt;
    logic                      wrap;

    logic [4*NUM_DIGITS-1:0]   pend_val, act_val, act_val_nxt;
    logic [NUM_DIGITS-1:0]     pend_dp, act_dp, act_dp_nxt;
    logic [NUM_DIGITS-1:0]     pend_blank, act_blank, act_blank_nxt;
    logic                      pend_valid;

    logic [NUM_DIGITS-1:0]     dark;
    logic                      all_zero;
    logic                      in_guard;
    logic [6:0]                seg_d;
    logic                      seg_dp_d;
    logic [NUM_DIGITS-1:0]     digit_en_d;
    logic                      frame_tick_d;

    // Next-state decode; outputs are derived from these so they line up with cnt/idx.
    always_comb begin
        wrap          = (cnt == CNT_MAX);
        cnt_nxt       = wrap ? '0 : cnt + 1'b1;
        idx_nxt       = idx;
        act_val_nxt   = act_val;
        act_dp_nxt    = act_dp;
        act_blank_nxt = act_blank;
        if (wrap) begin
            idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
            if (load) begin
                act_val_nxt   = value;
                act_dp_nxt    = dp;
                act_blank_nxt = blank;
            end else if (pend_valid) begin
                act_val_nxt   = pend_val;
                act_dp_nxt    = pend_dp;
                act_blank_nxt = pend_blank;
            end
        end
    end

    // Leading-zero suppression scans from the most significant digit downwards.
    always_comb begin
        all_zero = 1'b1;
        dark     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (act_val_nxt[4*i +: 4] == 4'h0);
            dark[i]  = act_blank_nxt[i] | ((LZ_BLANK != 0) && (i > 0) && all_zero);
        end
    end

    always_comb begin
        in_guard     = (cnt_nxt < GUARD_C);
        seg_d        = 7'h7F;
        seg_dp_d     = 1'b1;
        digit_en_d   = '1;
        frame_tick_d = (cnt_nxt == '0) && (idx_nxt == '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((idx_nxt == IW'(i)) && !in_guard && !dark[i]) begin
                digit_en_d[i] = 1'b0;
                seg_d         = font_n(act_val_nxt[4*i +: 4]);
                seg_dp_d      = ~act_dp_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

    // A load on the wrap cycle goes straight to the active buffer, so pending is left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else begin
            act_val   <= act_val_nxt;
            act_dp    <= act_dp_nxt;
            act_blank <= act_blank_nxt;
            if (wrap) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_val   <= value;
                pend_dp    <= dp;
                pend_blank <= blank;
                pend_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= 7'h7F;
            seg_dp     <= 1'b1;
            digit_en   <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_d;
            seg_dp     <= seg_dp_d;
            digit_en   <= digit_en_d;
            frame_tick <= frame_tick_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: one instance without and one with leading-zero blanking.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        load;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  en_a, en_b;
    logic        ft_a, ft_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(8), .GUARD(2), .LZ_BLANK(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .blank(blank), .load(load),
        .seg(seg_a), .seg_dp(dp_a), .digit_en(en_a), .frame_tick(ft_a)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(8), .GUARD(2), .LZ_BLANK(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .blank(blank), .load(load),
        .seg(seg_b), .seg_dp(dp_b), .digit_en(en_b), .frame_tick(ft_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc counts rising edges since the last reset release, so cnt = cyc%8, idx = (cyc/8)%4.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic align(input int pos);
        while ((cyc % 32) != pos) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; value = '0; dp = '0; blank = '0; load = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (seg_a !== 7'h7F || dp_a !== 1'b1 || en_a !== 4'hF || ft_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: seg=%h dp=%b en=%h ft=%b, want 7f 1 f 0", seg_a, dp_a, en_a, ft_a);
        end
        @(posedge clk);
        #7 rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (en_a !== ((k < 2) ? 4'hF : 4'hE)) begin
                errors++;
                $display("FAIL reset_first_digit cnt=%0d: en=%h want %h", k, en_a, (k < 2) ? 4'hF : 4'hE);
            end
            if (k < 2) step();
        end
        checks++;
        if (seg_a !== 7'h40 || dp_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_seg: seg=%h dp=%b want 40 1", seg_a, dp_a);
        end
        step(); step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg_a !== 7'h7F || dp_a !== 1'b1 || en_a !== 4'hF || ft_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: seg=%h dp=%b en=%h ft=%b, want 7f 1 f 0", seg_a, dp_a, en_a, ft_a);
        end
        #1 rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_basic_scan();
        logic [3:0] en_t  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] seg_t [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        logic       dp_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        align(31);
        value = 16'h12AF; dp = 4'b0100; blank = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 32; k++) begin
            int s = k / 8;
            int c = k % 8;
            logic [3:0] we = (c < 2) ? 4'hF : en_t[s];
            logic [6:0] ws = (c < 2) ? 7'h7F : seg_t[s];
            logic       wd = (c < 2) ? 1'b1 : dp_t[s];
            checks++;
            if (en_a !== we || seg_a !== ws || dp_a !== wd) begin
                errors++;
                $display("FAIL basic_scan slot=%0d cnt=%0d: en=%h seg=%h dp=%b want %h %h %b",
                         s, c, en_a, seg_a, dp_a, we, ws, wd);
            end
            checks++;
            if (ft_a !== (k == 0)) begin
                errors++;
                $display("FAIL frame_tick k=%0d: got %b want %b", k, ft_a, (k == 0));
            end
            step();
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] v_t   [3] = '{16'h0005, 16'h0000, 16'h0105};
        logic [3:0]  d_t   [3] = '{4'b1000, 4'b0000, 4'b0000};
        logic [3:0]  en_t  [3][4] = '{'{4'hE, 4'hF, 4'hF, 4'hF},
                                      '{4'hE, 4'hF, 4'hF, 4'hF},
                                      '{4'hE, 4'hD, 4'hB, 4'hF}};
        logic [6:0]  seg_t [3][4] = '{'{7'h12, 7'h7F, 7'h7F, 7'h7F},
                                      '{7'h40, 7'h7F, 7'h7F, 7'h7F},
                                      '{7'h12, 7'h40, 7'h79, 7'h7F}};
        for (int v = 0; v < 3; v++) begin
            align(31);
            value = v_t[v]; dp = d_t[v]; blank = 4'b0000; load = 1'b1;
            step();
            load = 1'b0;
            for (int k = 0; k < 32; k++) begin
                int s = k / 8;
                int c = k % 8;
                logic [3:0] we = (c < 2) ? 4'hF : en_t[v][s];
                logic [6:0] ws = (c < 2) ? 7'h7F : seg_t[v][s];
                checks++;
                if (en_b !== we || seg_b !== ws || dp_b !== 1'b1) begin
                    errors++;
                    $display("FAIL lz_blank val=%h slot=%0d cnt=%0d: en=%h seg=%h dp=%b want %h %h 1",
                             v_t[v], s, c, en_b, seg_b, dp_b, we, ws);
                end
                step();
            end
        end
    endtask

    task automatic test_blank_mask();
        logic [3:0] en_t  [4] = '{4'hE, 4'hF, 4'hB, 4'hF};
        logic [6:0] seg_t [4] = '{7'h0E, 7'h7F, 7'h24, 7'h7F};
        align(31);
        value = 16'h12AF; dp = 4'b0000; blank = 4'b1010; load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 32; k++) begin
            int s = k / 8;
            int c = k % 8;
            logic [3:0] we = (c < 2) ? 4'hF : en_t[s];
            logic [6:0] ws = (c < 2) ? 7'h7F : seg_t[s];
            checks++;
            if (en_a !== we || seg_a !== ws || dp_a !== 1'b1 || ft_a !== (k == 0)) begin
                errors++;
                $display("FAIL blank_mask slot=%0d cnt=%0d: en=%h seg=%h dp=%b ft=%b want %h %h 1 %b",
                         s, c, en_a, seg_a, dp_a, ft_a, we, ws, (k == 0));
            end
            step();
        end
    endtask

    task automatic test_double_buffer();
        align(31);
        value = 16'h0105; dp = 4'b0000; blank = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        align(12);
        value = 16'h1111; load = 1'b1;
        step();
        load = 1'b0; value = 16'hFFFF;
        for (int k = 13; k < 16; k++) begin
            checks++;
            if (en_a !== 4'hD || seg_a !== 7'h40) begin
                errors++;
                $display("FAIL no_tear cnt=%0d: en=%h seg=%h want d 40", k % 8, en_a, seg_a);
            end
            step();
        end
        for (int k = 16; k < 24; k++) begin
            logic [3:0] we = ((k % 8) < 2) ? 4'hF : 4'hB;
            logic [6:0] ws = ((k % 8) < 2) ? 7'h7F : 7'h79;
            checks++;
            if (en_a !== we || seg_a !== ws) begin
                errors++;
                $display("FAIL pending_apply cnt=%0d: en=%h seg=%h want %h %h", k % 8, en_a, seg_a, we, ws);
            end
            if (k < 23) step();
        end
        value = 16'h8888; load = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        for (int k = 26; k < 32; k++) begin
            checks++;
            if (en_a !== 4'h7 || seg_a !== 7'h00) begin
                errors++;
                $display("FAIL boundary_load cnt=%0d: en=%h seg=%h want 7 00", k % 8, en_a, seg_a);
            end
            step();
        end
        align(10);
        value = 16'h3333; load = 1'b1;
        step();
        load = 1'b0;
        step();
        value = 16'h4444; load = 1'b1;
        step();
        load = 1'b0;
        align(18);
        for (int k = 18; k < 24; k++) begin
            checks++;
            if (en_a !== 4'hB || seg_a !== 7'h19) begin
                errors++;
                $display("FAIL last_load_wins cnt=%0d: en=%h seg=%h want b 19", k % 8, en_a, seg_a);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lz_blank();
        test_blank_mask();
        test_double_buffer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
